// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: state encodings and width helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_adder_ctrl_pkg;

  // State register width and encodings; 2'd3 is unused and treated as IDLE.
  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit counter width: enough to index WIDTH bits, never less than one bit.
  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full adder cell shared by the serial datapath.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module serial_adder_ctrl_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic r,
  output logic cout
);

  assign r    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder reused LSB-first, carry held in a register.
// Latency: start accepted at edge N -> done pulse in the cycle after edge N+WIDTH.
// Backpressure: start only taken while ready (IDLE); requests during RUN/DONE are dropped.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic             carry_q;
  logic             fa_r;
  logic             fa_cout;
  logic             accept;
  logic             last_bit;

  assign accept   = start & ready;
  assign last_bit = (count_q == LAST);

  // New result bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  assign res_next = (res_sh >> 1) | (WIDTH'(fa_r) << (WIDTH - 1));

  serial_adder_ctrl_full_adder u_full_adder (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry_q),
    .r    (fa_r),
    .cout (fa_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; the unused encoding behaves exactly like IDLE.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_RUN:  state_d = last_bit ? ST_DONE : ST_RUN;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = accept ? ST_RUN : ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      ST_RUN:  busy  = 1'b1;
      ST_DONE: done  = 1'b1;
      default: ready = 1'b1;
    endcase
  end

  // Operand shifters, carry, bit counter and result registers; sum/cout only update on the last bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (accept) begin
      a_sh    <= a;
      b_sh    <= b;
      carry_q <= 1'b0;
      count_q <= '0;
    end else if (state_q == ST_RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      res_sh  <= res_next;
      carry_q <= fa_cout;
      if (last_bit) begin
        sum  <= res_next;
        cout <= fa_cout;
      end else begin
        count_q <= count_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed plus randomized bench for the bit-serial adder, WIDTH=8 and WIDTH=1 builds.
// Expected results come from plain integer addition of the requested operands.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       ready1;
  logic       busy1;
  logic       done1;
  logic [0:0] sum1;
  logic       cout1;

  int checks = 0;
  int errors = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .ready (ready1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 request; watches a fixed window of cycles after the accept edge.
  // inject_k: cycle at which a conflicting start is raised; reset_k: cycle at which reset is raised.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input int inject_k,
                     input int reset_k, output int lat, output int pulses,
                     output logic [7:0] mid_sum, output logic mid_busy);
    lat      = 0;
    pulses   = 0;
    mid_sum  = 'x;
    mid_busy = 1'b0;
    @(negedge clk);
    check("ready_before_accept", 32'(ready), 32'd1);
    start = 1'b1;
    a     = av;
    b     = bv;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      a     = 8'($urandom);
      b     = 8'($urandom);
      if (k == inject_k) begin
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
      end
      if (k == reset_k) reset = 1'b1;
      if (reset_k > 0 && k == reset_k + 1) begin
        reset = 1'b0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
      end
      if (k == 1) mid_busy = busy;
      if (k == 4) mid_sum = sum;
      if (done === 1'b1) begin
        pulses++;
        if (lat == 0) lat = k;
      end
    end
  endtask

  task automatic op1(input logic av, input logic bv, output int lat, output int pulses);
    lat    = 0;
    pulses = 0;
    @(negedge clk);
    check("w1_ready_before_accept", 32'(ready1), 32'd1);
    start1 = 1'b1;
    a1     = av;
    b1     = bv;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      a1     = ~av;
      b1     = ~bv;
      if (k == 1) check("w1_busy_run", 32'(busy1), 32'd1);
      if (done1 === 1'b1) begin
        pulses++;
        if (lat == 0) lat = k;
      end
    end
  endtask

  initial begin
    int         lat;
    int         pulses;
    logic [7:0] mid_sum;
    logic       mid_busy;
    logic [8:0] exp9;
    logic [7:0] prev_sum;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [1:0] exp2;

    reset  = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    start1 = 1'b0;
    a1     = '0;
    b1     = '0;

    // Reset held for two cycles.
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_w1_sum", 32'({cout1, sum1}), 32'd0);

    // FF + 01: full carry ripple.
    op8(8'hFF, 8'h01, 0, 0, lat, pulses, mid_sum, mid_busy);
    check("ff01_latency", 32'(lat), 32'd9);
    check("ff01_pulses", 32'(pulses), 32'd1);
    check("ff01_busy", 32'(mid_busy), 32'd1);
    check("ff01_mid_sum", 32'(mid_sum), 32'd0);
    check("ff01_sum", 32'(sum), 32'h00);
    check("ff01_cout", 32'(cout), 32'd1);

    // A5 + 5A: no carries at all; previous result visible while running.
    op8(8'hA5, 8'h5A, 0, 0, lat, pulses, mid_sum, mid_busy);
    check("a55a_mid_sum", 32'(mid_sum), 32'h00);
    check("a55a_sum", 32'(sum), 32'hFF);
    check("a55a_cout", 32'(cout), 32'd0);

    // 80 + 80: carry only out of the MSB.
    op8(8'h80, 8'h80, 0, 0, lat, pulses, mid_sum, mid_busy);
    check("8080_mid_sum", 32'(mid_sum), 32'hFF);
    check("8080_sum", 32'(sum), 32'h00);
    check("8080_cout", 32'(cout), 32'd1);

    // 3 + 4 with a conflicting start three cycles after accept.
    op8(8'd3, 8'd4, 3, 0, lat, pulses, mid_sum, mid_busy);
    check("busy_start_pulses", 32'(pulses), 32'd1);
    check("busy_start_latency", 32'(lat), 32'd9);
    check("busy_start_sum", 32'(sum), 32'h07);
    check("busy_start_cout", 32'(cout), 32'd0);

    // Reset four cycles into RUN aborts with no done pulse.
    op8(8'hC3, 8'h7E, 0, 4, lat, pulses, mid_sum, mid_busy);
    check("abort_pulses", 32'(pulses), 32'd0);
    check("abort_sum_after", 32'(sum), 32'd0);

    op8(8'd1, 8'd1, 0, 0, lat, pulses, mid_sum, mid_busy);
    check("post_abort_sum", 32'(sum), 32'h02);
    check("post_abort_cout", 32'(cout), 32'd0);
    check("post_abort_latency", 32'(lat), 32'd9);

    // Random operands against integer addition.
    prev_sum = 8'h02;
    for (int i = 0; i < 16; i++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      exp9 = 9'(ra) + 9'(rb);
      op8(ra, rb, 0, 0, lat, pulses, mid_sum, mid_busy);
      check("rand_latency", 32'(lat), 32'd9);
      check("rand_pulses", 32'(pulses), 32'd1);
      check("rand_mid_sum", 32'(mid_sum), 32'(prev_sum));
      check("rand_result", 32'({cout, sum}), 32'(exp9));
      prev_sum = exp9[7:0];
    end

    // WIDTH=1 build: every operand pair.
    for (int i = 0; i < 4; i++) begin
      exp2 = 2'(i[1]) + 2'(i[0]);
      op1(i[1], i[0], lat, pulses);
      check("w1_latency", 32'(lat), 32'd2);
      check("w1_pulses", 32'(pulses), 32'd1);
      check("w1_result", 32'({cout1, sum1}), 32'(exp2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
